// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM-port arbiter: access-size codes, FSM state
// encoding, the IO window base address and the size-code decoder.
package mem_arbiter_pkg;

    localparam logic [1:0]  AimByte       = 2'b01;
    localparam logic [1:0]  AimHalf       = 2'b10;
    localparam logic [1:0]  AimWord       = 2'b00;
    localparam logic [31:0] IoBaseDefault = 32'h0003_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    // Number of byte cycles for an SLB access-size code.
    function automatic logic [2:0] aim_to_bytes(input logic [1:0] aim);
        case (aim)
            AimByte: return 3'd1;
            AimHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the 8-bit RAM port. Arbitrates instruction fetch
// against the store/load buffer, splits accesses into little-endian byte
// cycles and reports completion on shared finish strobes.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   rdy                      global enable, low freezes every register
//   is_exception_from_rob    flush: aborts reads, lets an active write finish
//   is_req_from_if / addr_from_if / data_to_if / is_finish_to_if   fetch side
//   is_empty_from_slb (low pulse = request), is_store_from_slb, addr_from_slb,
//   data_from_slb, aim_from_slb, data_to_slb, is_finish_to_slb,
//   is_instr_to_slb, is_store_to_slb                               SLB side
//   mem_din, mem_dout, mem_a, mem_wr                               RAM port
//   io_buffer_full           stalls writes into the IO window
//
// state  | meaning
// IDLE   | no transaction; arbitrate slot/pulse against fetch
// READ   | issuing byte addresses and capturing returned bytes
// WRITE  | issuing byte writes, stalled by a full IO sink
// DONE   | drive finish strobes, free the SLB slot
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                  AddrLength = 31,
    parameter int                  CntLength  = 1,
    parameter logic [AddrLength:0] IoBase     = IoBaseDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  is_exception_from_rob,
    input  logic                  is_req_from_if,
    input  logic [AddrLength:0]   addr_from_if,
    output logic [31:0]           data_to_if,
    output logic                  is_finish_to_if,
    input  logic                  is_empty_from_slb,
    input  logic                  is_store_from_slb,
    input  logic [AddrLength:0]   addr_from_slb,
    input  logic [31:0]           data_from_slb,
    input  logic [CntLength:0]    aim_from_slb,
    output logic [31:0]           data_to_slb,
    output logic                  is_finish_to_slb,
    output logic                  is_instr_to_slb,
    output logic                  is_store_to_slb,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [AddrLength:0]   mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    arb_state_e            state_q;
    logic                  last_grant_slb_q;
    logic                  slot_valid_q, slot_store_q;
    logic [AddrLength:0]   slot_addr_q;
    logic [31:0]           slot_data_q;
    logic [CntLength:0]    slot_aim_q;
    logic                  cur_instr_q, cur_store_q;
    logic [AddrLength:0]   base_q;
    logic [31:0]           wdata_q, rbuf_q;
    logic [2:0]            nbytes_q, k_q;
    logic [AddrLength:0]   mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic [31:0]           data_to_if_q, data_to_slb_q;
    logic                  fin_if_q, fin_slb_q, instr_q, store_q;

    logic                  slb_pulse, accept_pulse, slot_valid_d;
    logic                  grant_slb_d, grant_if_d, io_block;
    logic                  pick_store;
    logic [AddrLength:0]   pick_addr;
    logic [31:0]           pick_data;
    logic [CntLength:0]    pick_aim;
    logic [1:0]            cap_idx;

    always_comb begin
        slb_pulse    = ~is_empty_from_slb;
        // A request arriving this cycle is visible to arbitration before it lands in the slot.
        pick_store   = slot_valid_q ? slot_store_q : is_store_from_slb;
        pick_addr    = slot_valid_q ? slot_addr_q  : addr_from_slb;
        pick_data    = slot_valid_q ? slot_data_q  : data_from_slb;
        pick_aim     = slot_valid_q ? slot_aim_q   : aim_from_slb;
        grant_slb_d  = (slot_valid_q | slb_pulse) & (~is_req_from_if | ~last_grant_slb_q);
        grant_if_d   = is_req_from_if & ~grant_slb_d;
        // A flush drops pending loads but never a store, queued or arriving.
        accept_pulse = slb_pulse & ~(is_exception_from_rob & ~is_store_from_slb);
        slot_valid_d = accept_pulse
                     | (slot_valid_q
                        & ~((state_q == StDone) & ~cur_instr_q)
                        & ~(is_exception_from_rob & ~slot_store_q));
        io_block     = cur_store_q & (base_q >= IoBase) & io_buffer_full;
        cap_idx      = k_q[1:0] - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            last_grant_slb_q <= 1'b1;
            slot_valid_q     <= 1'b0;
            slot_store_q     <= 1'b0;
            slot_addr_q      <= '0;
            slot_data_q      <= '0;
            slot_aim_q       <= '0;
            cur_instr_q      <= 1'b0;
            cur_store_q      <= 1'b0;
            base_q           <= '0;
            wdata_q          <= '0;
            rbuf_q           <= '0;
            nbytes_q         <= '0;
            k_q              <= '0;
            mem_a_q          <= '0;
            mem_dout_q       <= '0;
            mem_wr_q         <= 1'b0;
            data_to_if_q     <= '0;
            data_to_slb_q    <= '0;
            fin_if_q         <= 1'b0;
            fin_slb_q        <= 1'b0;
            instr_q          <= 1'b0;
            store_q          <= 1'b0;
        end else if (rdy) begin
            slot_valid_q <= slot_valid_d;
            if (accept_pulse) begin
                slot_store_q <= is_store_from_slb;
                slot_addr_q  <= addr_from_slb;
                slot_data_q  <= data_from_slb;
                slot_aim_q   <= aim_from_slb;
            end
            fin_if_q  <= 1'b0;
            fin_slb_q <= 1'b0;
            instr_q   <= 1'b0;
            store_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!is_exception_from_rob && (grant_if_d || grant_slb_d)) begin
                        cur_instr_q      <= grant_if_d;
                        cur_store_q      <= grant_slb_d & pick_store;
                        base_q           <= grant_if_d ? addr_from_if : pick_addr;
                        wdata_q          <= pick_data;
                        nbytes_q         <= grant_if_d ? 3'd4 : aim_to_bytes(pick_aim);
                        k_q              <= 3'd0;
                        rbuf_q           <= '0;
                        last_grant_slb_q <= grant_slb_d;
                        state_q          <= (grant_slb_d && pick_store) ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (is_exception_from_rob) begin
                        state_q <= StIdle;
                    end else begin
                        // Byte addressed on the previous edge is on mem_din now.
                        if (k_q != 3'd0) rbuf_q[{cap_idx, 3'b000} +: 8] <= mem_din;
                        if (k_q == nbytes_q) begin
                            state_q <= StDone;
                        end else begin
                            mem_a_q <= base_q + (AddrLength+1)'(k_q);
                            k_q     <= k_q + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    if (io_block) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a_q    <= base_q + (AddrLength+1)'(k_q);
                        mem_dout_q <= wdata_q[{k_q[1:0], 3'b000} +: 8];
                        mem_wr_q   <= 1'b1;
                        k_q        <= k_q + 3'd1;
                        if (k_q + 3'd1 == nbytes_q) state_q <= StDone;
                    end
                end
                StDone: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= StIdle;
                    if (!(is_exception_from_rob && !cur_store_q)) begin
                        fin_slb_q <= 1'b1;
                        instr_q   <= cur_instr_q;
                        store_q   <= cur_store_q;
                        if (cur_instr_q) begin
                            fin_if_q     <= 1'b1;
                            data_to_if_q <= rbuf_q;
                        end else if (!cur_store_q) begin
                            data_to_slb_q <= rbuf_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_a            = mem_a_q;
    assign mem_dout         = mem_dout_q;
    assign mem_wr           = mem_wr_q & rdy;
    assign data_to_if       = data_to_if_q;
    assign data_to_slb      = data_to_slb_q;
    assign is_finish_to_if  = fin_if_q;
    assign is_finish_to_slb = fin_slb_q;
    assign is_instr_to_slb  = instr_q;
    assign is_store_to_slb  = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, is_exception_from_rob, is_req_from_if;
    logic [31:0] addr_from_if, data_to_if;
    logic        is_finish_to_if;
    logic        is_empty_from_slb, is_store_from_slb;
    logic [31:0] addr_from_slb, data_from_slb, data_to_slb;
    logic [1:0]  aim_from_slb;
    logic        is_finish_to_slb, is_instr_to_slb, is_store_to_slb;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram [0:65535];
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    logic        fi[$];
    logic        fs[$];
    logic [31:0] fd[$];
    int          cyc = 0;
    int          slb_done = 0;
    int          slb_issued = 0;

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[15:0]];

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .is_exception_from_rob(is_exception_from_rob),
        .is_req_from_if(is_req_from_if), .addr_from_if(addr_from_if),
        .data_to_if(data_to_if), .is_finish_to_if(is_finish_to_if),
        .is_empty_from_slb(is_empty_from_slb), .is_store_from_slb(is_store_from_slb),
        .addr_from_slb(addr_from_slb), .data_from_slb(data_from_slb),
        .aim_from_slb(aim_from_slb), .data_to_slb(data_to_slb),
        .is_finish_to_slb(is_finish_to_slb), .is_instr_to_slb(is_instr_to_slb),
        .is_store_to_slb(is_store_to_slb),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        cyc++;
        if (mem_wr) begin
            wa.push_back(mem_a);
            wd.push_back(mem_dout);
            wc.push_back(cyc);
        end
        if (is_finish_to_slb) begin
            fi.push_back(is_instr_to_slb);
            fs.push_back(is_store_to_slb);
            fd.push_back(is_instr_to_slb ? data_to_if : data_to_slb);
            if (!is_instr_to_slb) slb_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        is_empty_from_slb     = 1'b1;
        is_exception_from_rob = 1'b0;
    endtask

    // The slot holds one request; a second one is only legal while the first is finishing.
    task automatic slb_req(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [1:0] aim);
        if (slb_issued - slb_done > 1) begin
            $display("FAIL slb_overlap: outstanding %0d requests, allowed 1", slb_issued - slb_done);
            $fatal(1, "illegal SLB request while slot occupied");
        end
        slb_issued++;
        is_store_from_slb = st;
        addr_from_slb     = a;
        data_from_slb     = d;
        aim_from_slb      = aim;
        is_empty_from_slb = 1'b0;
    endtask

    task automatic wait_slb(input int budget, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (is_finish_to_slb !== 1'b1 && edges < budget);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_checks++; if (data_to_if !== 32'h0) begin n_fail++; $display("FAIL reset_data_to_if: got %h want 0", data_to_if); end
        n_checks++; if (data_to_slb !== 32'h0) begin n_fail++; $display("FAIL reset_data_to_slb: got %h want 0", data_to_slb); end
        n_checks++; if (is_finish_to_if !== 1'b0) begin n_fail++; $display("FAIL reset_fin_if: got %b want 0", is_finish_to_if); end
        n_checks++; if (is_finish_to_slb !== 1'b0) begin n_fail++; $display("FAIL reset_fin_slb: got %b want 0", is_finish_to_slb); end
        n_checks++; if ({is_instr_to_slb, is_store_to_slb} !== 2'b00) begin n_fail++; $display("FAIL reset_tags: got %b want 00", {is_instr_to_slb, is_store_to_slb}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int e;
        int w0 = wa.size();
        is_req_from_if = 1'b1;
        addr_from_if   = 32'h100;
        e = 0;
        do begin tick(); e++; end while (is_finish_to_if !== 1'b1 && e < 20);
        n_checks++; if (e !== 7) begin n_fail++; $display("FAIL fetch_latency: got %0d edges want 7", e); end
        n_checks++; if (data_to_if !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data: got %h want 00000513", data_to_if); end
        n_checks++; if ({is_finish_to_slb, is_instr_to_slb, is_store_to_slb} !== 3'b110) begin n_fail++; $display("FAIL fetch_tags: got %b want 110", {is_finish_to_slb, is_instr_to_slb, is_store_to_slb}); end
        is_req_from_if = 1'b0;
        tick();
        n_checks++; if ({is_finish_to_if, is_finish_to_slb} !== 2'b00) begin n_fail++; $display("FAIL fetch_strobe_drop: got %b want 00", {is_finish_to_if, is_finish_to_slb}); end
        n_checks++; if (data_to_if !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data_hold: got %h want 00000513", data_to_if); end
        n_checks++; if (wa.size() !== w0) begin n_fail++; $display("FAIL fetch_no_write: got %0d writes want 0", wa.size() - w0); end
        // address wraps past 0xFFFFFFFF
        is_req_from_if = 1'b1;
        addr_from_if   = 32'hFFFF_FFFE;
        e = 0;
        do begin tick(); e++; end while (is_finish_to_if !== 1'b1 && e < 20);
        n_checks++; if (data_to_if !== 32'h1234_5678 || e !== 7) begin n_fail++; $display("FAIL fetch_wrap: got %h after %0d edges want 12345678 after 7", data_to_if, e); end
        is_req_from_if = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int e;
        slb_req(1'b0, 32'h1003, 32'h0, 2'b01);
        wait_slb(20, e);
        n_checks++; if (e !== 4) begin n_fail++; $display("FAIL lb_latency: got %0d edges want 4", e); end
        n_checks++; if (data_to_slb !== 32'h0000_0080) begin n_fail++; $display("FAIL lb_data: got %h want 00000080", data_to_slb); end
        n_checks++; if ({is_instr_to_slb, is_store_to_slb, is_finish_to_if} !== 3'b000) begin n_fail++; $display("FAIL lb_tags: got %b want 000", {is_instr_to_slb, is_store_to_slb, is_finish_to_if}); end
        n_checks++; if (mem_a !== 32'h1003) begin n_fail++; $display("FAIL lb_single_read: last addr %h want 00001003", mem_a); end
        tick();
        slb_req(1'b0, 32'h1002, 32'h0, 2'b10);
        wait_slb(20, e);
        n_checks++; if (data_to_slb !== 32'h0000_807F || e !== 5) begin n_fail++; $display("FAIL lh_data: got %h after %0d edges want 0000807f after 5", data_to_slb, e); end
        tick();
    endtask

    task automatic test_store();
        int e;
        int w0 = wa.size();
        logic [31:0] v = 32'hDEAD_BEEF;
        slb_req(1'b1, 32'h2000, v, 2'b00);
        wait_slb(20, e);
        n_checks++; if (e !== 6) begin n_fail++; $display("FAIL sw_latency: got %0d edges want 6", e); end
        n_checks++; if ({is_instr_to_slb, is_store_to_slb} !== 2'b01) begin n_fail++; $display("FAIL sw_tags: got %b want 01", {is_instr_to_slb, is_store_to_slb}); end
        n_checks++; if (wa.size() - w0 !== 4) begin n_fail++; $display("FAIL sw_count: got %0d writes want 4", wa.size() - w0); end
        if (wa.size() - w0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wa[w0+i] !== 32'h2000 + i || wd[w0+i] !== v[8*i +: 8] || wc[w0+i] !== wc[w0] + i) begin
                    n_fail++;
                    $display("FAIL sw_byte%0d: got addr %h data %h cycle+%0d want addr %h data %h cycle+%0d", i, wa[w0+i], wd[w0+i], wc[w0+i] - wc[w0], 32'h2000 + i, v[8*i +: 8], i);
                end
            end
        end
        tick();
    endtask

    task automatic test_alternation();
        int f0;
        is_req_from_if = 1'b1;
        addr_from_if   = 32'h40;
        for (int i = 0; i < 20 && is_finish_to_if !== 1'b1; i++) tick();
        is_req_from_if = 1'b0;
        tick();
        f0 = fi.size();
        is_req_from_if = 1'b1;
        slb_req(1'b0, 32'h50, 32'h0, 2'b01);
        tick();
        tick();
        tick();
        slb_req(1'b0, 32'h51, 32'h0, 2'b01);
        tick();
        for (int i = 0; i < 40 && fi.size() - f0 < 3; i++) begin
            tick();
            if (is_finish_to_if === 1'b1) is_req_from_if = 1'b0;
        end
        is_req_from_if = 1'b0;
        n_checks++; if (fi.size() - f0 !== 3) begin n_fail++; $display("FAIL alt_count: got %0d finishes want 3", fi.size() - f0); end
        if (fi.size() - f0 >= 3) begin
            n_checks++; if (fi[f0] !== 1'b0 || fd[f0] !== 32'h11) begin n_fail++; $display("FAIL alt_first: got instr %b data %h want instr 0 data 00000011", fi[f0], fd[f0]); end
            n_checks++; if (fi[f0+1] !== 1'b1 || fd[f0+1] !== 32'h1122_3344) begin n_fail++; $display("FAIL alt_second: got instr %b data %h want instr 1 data 11223344", fi[f0+1], fd[f0+1]); end
            n_checks++; if (fi[f0+2] !== 1'b0 || fd[f0+2] !== 32'h22) begin n_fail++; $display("FAIL alt_third: got instr %b data %h want instr 0 data 00000022", fi[f0+2], fd[f0+2]); end
        end
        tick();
    endtask

    task automatic test_io_hold();
        int w0 = wa.size();
        io_buffer_full = 1'b1;
        slb_req(1'b1, 32'h3_0000, 32'hA5, 2'b01);
        tick();
        tick();
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL io_hold1: mem_wr %b want 0", mem_wr); end
        tick();
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL io_hold2: mem_wr %b want 0", mem_wr); end
        io_buffer_full = 1'b0;
        tick();
        n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000 || mem_dout !== 8'hA5) begin n_fail++; $display("FAIL io_release: got wr %b addr %h data %h want 1 00030000 a5", mem_wr, mem_a, mem_dout); end
        tick();
        n_checks++; if ({is_finish_to_slb, is_store_to_slb, mem_wr} !== 3'b110) begin n_fail++; $display("FAIL io_finish: got fin/store/wr %b want 110", {is_finish_to_slb, is_store_to_slb, mem_wr}); end
        n_checks++; if (wa.size() - w0 !== 1) begin n_fail++; $display("FAIL io_count: got %0d writes want 1", wa.size() - w0); end
        tick();
    endtask

    task automatic test_rdy_freeze();
        int w0 = wa.size();
        slb_req(1'b1, 32'h2100, 32'h3C, 2'b01);
        tick();
        tick();
        n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rdy_pre_write: mem_wr %b want 1", mem_wr); end
        rdy = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h2100) begin n_fail++; $display("FAIL rdy_force: got wr %b addr %h want 0 00002100", mem_wr, mem_a); end
        tick();
        tick();
        tick();
        n_checks++; if (is_finish_to_slb !== 1'b0 || mem_a !== 32'h2100) begin n_fail++; $display("FAIL rdy_hold: got fin %b addr %h want 0 00002100", is_finish_to_slb, mem_a); end
        rdy = 1'b1;
        tick();
        n_checks++; if ({is_finish_to_slb, is_store_to_slb} !== 2'b11) begin n_fail++; $display("FAIL rdy_resume: got fin/store %b want 11", {is_finish_to_slb, is_store_to_slb}); end
        n_checks++; if (wa.size() - w0 !== 1) begin n_fail++; $display("FAIL rdy_count: got %0d writes want 1", wa.size() - w0); end
        tick();
    endtask

    task automatic test_exception();
        int e;
        int w0;
        int f0 = fi.size();
        logic seen = 1'b0;
        logic [31:0] v = 32'h1122_3344;
        is_req_from_if = 1'b1;
        addr_from_if   = 32'h100;
        tick();
        tick();
        tick();
        is_exception_from_rob = 1'b1;
        is_req_from_if        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | is_finish_to_if | is_finish_to_slb;
        end
        n_checks++; if (seen !== 1'b0 || fi.size() !== f0) begin n_fail++; $display("FAIL exc_fetch_abort: got finish seen %b count %0d want 0 0", seen, fi.size() - f0); end
        slb_req(1'b0, 32'h1003, 32'h0, 2'b01);
        wait_slb(20, e);
        n_checks++; if (e !== 4 || data_to_slb !== 32'h80) begin n_fail++; $display("FAIL exc_idle_after: got %h after %0d edges want 00000080 after 4", data_to_slb, e); end
        tick();
        w0 = wa.size();
        slb_req(1'b1, 32'h2200, v, 2'b00);
        tick();
        tick();
        tick();
        is_exception_from_rob = 1'b1;
        wait_slb(20, e);
        n_checks++; if (e !== 3 || {is_store_to_slb, is_instr_to_slb} !== 2'b10) begin n_fail++; $display("FAIL exc_sw_finish: got %0d edges store/instr %b want 3 10", e, {is_store_to_slb, is_instr_to_slb}); end
        n_checks++; if (wa.size() - w0 !== 4) begin n_fail++; $display("FAIL exc_sw_count: got %0d writes want 4", wa.size() - w0); end
        if (wa.size() - w0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wa[w0+i] !== 32'h2200 + i || wd[w0+i] !== v[8*i +: 8]) begin
                    n_fail++;
                    $display("FAIL exc_sw_byte%0d: got addr %h data %h want addr %h data %h", i, wa[w0+i], wd[w0+i], 32'h2200 + i, v[8*i +: 8]);
                end
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        int w0 = wa.size();
        int f0 = fi.size();
        slb_req(1'b1, 32'h2300, 32'hCAFE_F00D, 2'b00);
        tick();
        tick();
        n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL arst_pre: mem_wr %b want 1", mem_wr); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin n_fail++; $display("FAIL arst_immediate: got wr %b addr %h data %h want 0 0 0", mem_wr, mem_a, mem_dout); end
        tick();
        tick();
        rst = 1'b0;
        slb_issued = slb_done;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (wa.size() !== w0 || fi.size() !== f0) begin n_fail++; $display("FAIL arst_no_resume: got %0d writes %0d finishes want 0 0", wa.size() - w0, fi.size() - f0); end
        f0 = fi.size();
        is_req_from_if = 1'b1;
        addr_from_if   = 32'h100;
        slb_req(1'b0, 32'h1003, 32'h0, 2'b01);
        for (int i = 0; i < 40 && fi.size() - f0 < 2; i++) begin
            tick();
            if (is_finish_to_if === 1'b1) is_req_from_if = 1'b0;
        end
        is_req_from_if = 1'b0;
        n_checks++; if (fi.size() - f0 !== 2) begin n_fail++; $display("FAIL arst_grant_count: got %0d finishes want 2", fi.size() - f0); end
        if (fi.size() - f0 >= 2) begin
            n_checks++; if (fi[f0] !== 1'b1 || fi[f0+1] !== 1'b0) begin n_fail++; $display("FAIL arst_grant_order: got instr %b then %b want 1 then 0", fi[f0], fi[f0+1]); end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'hFFFE] = 8'h78; ram[16'hFFFF] = 8'h56; ram[16'h0000] = 8'h34; ram[16'h0001] = 8'h12;
        ram[16'h1002] = 8'h7F; ram[16'h1003] = 8'h80; ram[16'h1004] = 8'hFF;
        ram[16'h0040] = 8'h44; ram[16'h0041] = 8'h33; ram[16'h0042] = 8'h22; ram[16'h0043] = 8'h11;
        ram[16'h0050] = 8'h11; ram[16'h0051] = 8'h22;
        rst                   = 1'b1;
        rdy                   = 1'b1;
        is_exception_from_rob = 1'b0;
        is_req_from_if        = 1'b0;
        addr_from_if          = 32'h0;
        is_empty_from_slb     = 1'b1;
        is_store_from_slb     = 1'b0;
        addr_from_slb         = 32'h0;
        data_from_slb         = 32'h0;
        aim_from_slb          = 2'b00;
        io_buffer_full        = 1'b0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_alternation();
        test_io_hold();
        test_rdy_freeze();
        test_exception();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
